// File: rtl/thread_cmd_issuer_pkg.sv
// Shared thread-command, controller-state and inter-CPU message codes for the
// CPU-side thread command issuer.
package thread_cmd_issuer_pkg;

  localparam logic [3:0] THREAD_CMD_NONE = 4'd0;
  localparam logic [3:0] THREAD_CMD_RUN  = 4'd1;
  localparam logic [3:0] THREAD_CMD_STOP = 4'd2;

  localparam logic [7:0] CTL_CPU_CMD     = 8'h05;

  localparam logic [7:0] CPU_R_FORK_DONE = 8'h31;
  localparam logic [7:0] CPU_R_STOP_DONE = 8'h32;

  localparam logic [1:0] THRD_RSLT_ACCEPT = 2'd1;

  localparam logic REQ_KIND_RUN  = 1'b0;
  localparam logic REQ_KIND_STOP = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_RSLT = 3'd2,
    ST_BACKOFF   = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  function automatic logic [3:0] cmd_for_kind(input logic kind);
    return (kind == REQ_KIND_STOP) ? THREAD_CMD_STOP : THREAD_CMD_RUN;
  endfunction

  function automatic logic [7:0] msg_for_kind(input logic kind);
    return (kind == REQ_KIND_STOP) ? CPU_R_STOP_DONE : CPU_R_FORK_DONE;
  endfunction

endpackage

// File: rtl/thread_cmd_issuer_if.sv
// Core request / manager command bundle for the thread command issuer.
// master = issuer side, slave = core + threads manager side.
interface thread_cmd_issuer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              clk_oe;
  logic [7:0]        ctl_state;
  logic              req_valid;
  logic              req_kind;
  logic [DATA_W-1:0] req_data;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic [3:0]        thrd_cmd;
  logic [DATA_W-1:0] data_out;
  logic [ADDR_W-1:0] addr_out;
  logic [1:0]        thrd_rslt;
  logic [7:0]        cpu_msg_out;
  logic              done_valid;
  logic              done_ok;
  logic              busy;

  modport master (
    input  clk_oe, ctl_state, req_valid, req_kind, req_data, req_addr, thrd_rslt,
    output req_ready, thrd_cmd, data_out, addr_out, cpu_msg_out, done_valid, done_ok, busy
  );

  modport slave (
    output clk_oe, ctl_state, req_valid, req_kind, req_data, req_addr, thrd_rslt,
    input  req_ready, thrd_cmd, data_out, addr_out, cpu_msg_out, done_valid, done_ok, busy
  );
endinterface

// File: rtl/thread_cmd_issuer.sv
// CPU-side initiator of the thread-command protocol: issues one RUN/STOP at a
// time, retries refusals after a back-off and reports completion.
//
// state     | meaning
// IDLE      | ready for a core request
// ISSUE     | command driven, waiting for the controller CPU_CMD edge
// WAIT_RSLT | command withdrawn, manager result sampled
// BACKOFF   | refused, counting idle cycles before the next attempt
// DONE      | one-cycle completion pulse (and FORK/STOP_DONE on success)
module thread_cmd_issuer #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_RETRY = 4,
  parameter int BACKOFF   = 3
) (
  input logic           clk,
  input logic           rst,
  thread_cmd_issuer_if.master bus
);
  import thread_cmd_issuer_pkg::*;

  localparam logic [3:0] MAX_RETRY_C = 4'(MAX_RETRY);
  localparam logic [3:0] BACKOFF_C   = 4'(BACKOFF);

  state_t            r_state;
  logic              r_kind;
  logic [3:0]        r_retry_cnt;
  logic [3:0]        r_bo_cnt;
  logic              r_req_ready;
  logic              r_busy;
  logic [3:0]        r_thrd_cmd;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_cpu_msg;
  logic              r_done_valid;
  logic              r_done_ok;

  logic [3:0]        w_retry_inc;
  logic [3:0]        w_bo_dec;

  assign w_retry_inc = (r_retry_cnt == 4'hF) ? 4'hF : r_retry_cnt + 4'd1;
  assign w_bo_dec    = (r_bo_cnt == 4'd0) ? 4'd0 : r_bo_cnt - 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_kind       <= REQ_KIND_RUN;
      r_retry_cnt  <= 4'd0;
      r_bo_cnt     <= 4'd0;
      r_req_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_thrd_cmd   <= THREAD_CMD_NONE;
      r_data       <= '0;
      r_addr       <= '0;
      r_cpu_msg    <= 8'd0;
      r_done_valid <= 1'b0;
      r_done_ok    <= 1'b0;
    end else if (bus.clk_oe) begin
      // completion outputs live for exactly one enabled cycle
      r_done_valid <= 1'b0;
      r_done_ok    <= 1'b0;
      r_cpu_msg    <= 8'd0;
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_kind      <= bus.req_kind;
            r_data      <= bus.req_data;
            r_addr      <= bus.req_addr;
            r_retry_cnt <= 4'd0;
            r_thrd_cmd  <= cmd_for_kind(bus.req_kind);
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus.ctl_state == CTL_CPU_CMD) begin
            r_thrd_cmd <= THREAD_CMD_NONE;
            r_state    <= ST_WAIT_RSLT;
          end
        end
        ST_WAIT_RSLT: begin
          if (bus.thrd_rslt == THRD_RSLT_ACCEPT) begin
            r_done_valid <= 1'b1;
            r_done_ok    <= 1'b1;
            r_cpu_msg    <= msg_for_kind(r_kind);
            r_state      <= ST_DONE;
          end else begin
            r_retry_cnt <= w_retry_inc;
            if (w_retry_inc == MAX_RETRY_C) begin
              r_done_valid <= 1'b1;
              r_state      <= ST_DONE;
            end else begin
              r_bo_cnt <= BACKOFF_C;
              r_state  <= ST_BACKOFF;
            end
          end
        end
        ST_BACKOFF: begin
          r_bo_cnt <= w_bo_dec;
          // leaving when the count reaches zero gives BACKOFF idle cycles
          if (w_bo_dec == 4'd0) begin
            r_thrd_cmd <= cmd_for_kind(r_kind);
            r_state    <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_thrd_cmd  <= THREAD_CMD_NONE;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.busy        = r_busy;
  assign bus.thrd_cmd    = r_thrd_cmd;
  assign bus.data_out    = r_data;
  assign bus.addr_out    = r_addr;
  assign bus.cpu_msg_out = r_cpu_msg;
  assign bus.done_valid  = r_done_valid;
  assign bus.done_ok     = r_done_ok;

endmodule

// File: tb/tb_thread_cmd_issuer.sv
// Self-checking bench for thread_cmd_issuer: a per-transaction expected trace is
// built from the protocol rules and compared against the DUT every cycle.
module tb_thread_cmd_issuer;
  import thread_cmd_issuer_pkg::*;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int MAX_RETRY = 4;
  localparam int BACKOFF   = 3;
  localparam int TMAX      = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  thread_cmd_issuer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  thread_cmd_issuer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_RETRY(MAX_RETRY), .BACKOFF(BACKOFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // expectations for the current cycle, consumed by the compare process
  logic        chk_en = 1'b0;
  logic [3:0]  e_cmd;
  logic        e_ready, e_busy, e_dv, e_ok, e_zero;
  logic [7:0]  e_msg;
  logic [31:0] e_data, e_addr;

  always @(negedge clk) begin
    if (chk_en) begin
      check("thrd_cmd",    64'(bus.thrd_cmd),    64'(e_cmd));
      check("req_ready",   64'(bus.req_ready),   64'(e_ready));
      check("busy",        64'(bus.busy),        64'(e_busy));
      check("done_valid",  64'(bus.done_valid),  64'(e_dv));
      check("done_ok",     64'(bus.done_ok),     64'(e_ok));
      check("cpu_msg_out", 64'(bus.cpu_msg_out), 64'(e_msg));
      if (e_cmd != THREAD_CMD_NONE || e_zero) begin
        check("data_out", 64'(bus.data_out), 64'(e_data));
        check("addr_out", 64'(bus.addr_out), 64'(e_addr));
      end
    end
  end

  // expected trace, index 0 = first cycle after the accepting edge
  logic [3:0] t_cmd [TMAX];
  logic       t_dv  [TMAX];
  logic       t_ok  [TMAX];
  logic [7:0] t_msg [TMAX];
  logic [7:0] t_ctl [TMAX];
  logic [1:0] t_rslt[TMAX];
  int         t_len;

  task automatic build_trace(input logic kind, input int wait_cyc, input int nref);
    int n = 0;
    int attempts;
    logic [3:0] cmd;
    logic ok;
    cmd = kind ? THREAD_CMD_STOP : THREAD_CMD_RUN;
    for (int k = 0; k < TMAX; k++) begin
      t_cmd[k] = THREAD_CMD_NONE; t_dv[k] = 1'b0; t_ok[k] = 1'b0;
      t_msg[k] = 8'd0; t_ctl[k] = 8'h00; t_rslt[k] = 2'd0;
    end
    attempts = (nref + 1 < MAX_RETRY) ? nref + 1 : MAX_RETRY;
    for (int a = 0; a < attempts; a++) begin
      for (int w = 0; w <= wait_cyc; w++) begin
        t_cmd[n] = cmd;
        if (w == wait_cyc) t_ctl[n] = CTL_CPU_CMD;
        n++;
      end
      if (a < nref) begin
        case (a % 3)
          0:       t_rslt[n] = 2'd0;
          1:       t_rslt[n] = 2'd2;
          default: t_rslt[n] = 2'd3;
        endcase
      end else begin
        t_rslt[n] = 2'd1;
      end
      n++;
      if (a < nref && a < MAX_RETRY - 1) begin
        for (int b = 0; b < BACKOFF; b++) begin
          t_ctl[n] = CTL_CPU_CMD;   // controller state during back-off must be ignored
          n++;
        end
      end
    end
    ok = (nref < MAX_RETRY);
    t_dv[n]  = 1'b1;
    t_ok[n]  = ok;
    t_msg[n] = ok ? (kind ? CPU_R_STOP_DONE : CPU_R_FORK_DONE) : 8'd0;
    n++;
    t_len = n;
  endtask

  task automatic set_idle_exp(input logic zero);
    e_cmd = THREAD_CMD_NONE; e_ready = 1'b1; e_busy = 1'b0;
    e_dv = 1'b0; e_ok = 1'b0; e_msg = 8'd0;
    e_zero = zero; e_data = 32'd0; e_addr = 32'd0;
  endtask

  task automatic run_txn(input logic kind, input logic [31:0] data, input logic [31:0] addr,
                         input int wait_cyc, input int nref, input int freeze_at,
                         input int freeze_len, input logic busy_valid, input int rst_at);
    int   i = 0;
    int   frz = 0;
    logic stop = 1'b0;
    build_trace(kind, wait_cyc, nref);
    bus.req_valid = 1'b1; bus.req_kind = kind; bus.req_data = data; bus.req_addr = addr;
    bus.clk_oe = 1'b1; bus.ctl_state = 8'h00; bus.thrd_rslt = 2'd0;
    set_idle_exp(1'b0);
    @(posedge clk); #1;
    bus.req_valid = busy_valid; bus.req_kind = ~kind;
    bus.req_data = 32'hDEAD_BEEF; bus.req_addr = 32'h0000_BAD0;
    while (i < t_len && !stop) begin
      bus.clk_oe    = !(i == freeze_at && frz < freeze_len);
      bus.ctl_state = t_ctl[i];
      bus.thrd_rslt = t_rslt[i];
      e_cmd = t_cmd[i]; e_ready = 1'b0; e_busy = 1'b1;
      e_dv = t_dv[i]; e_ok = t_ok[i]; e_msg = t_msg[i];
      e_data = data; e_addr = addr; e_zero = 1'b0;
      if (i == rst_at) rst = 1'b1;
      @(posedge clk); #1;
      if (rst) begin
        rst = 1'b0;
        stop = 1'b1;
      end else if (bus.clk_oe) begin
        i++;
      end else begin
        frz++;
      end
    end
    bus.clk_oe = 1'b1; bus.req_valid = 1'b0; bus.ctl_state = 8'h00; bus.thrd_rslt = 2'd0;
    set_idle_exp(stop);
    @(posedge clk); #1;
    set_idle_exp(stop);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.clk_oe = 1'b1; bus.ctl_state = 8'h00; bus.req_valid = 1'b0; bus.req_kind = 1'b0;
    bus.req_data = 32'd0; bus.req_addr = 32'd0; bus.thrd_rslt = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    set_idle_exp(1'b1);
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // RUN accepted first try: command for one cycle, done in the third cycle
    run_txn(REQ_KIND_RUN, 32'h0000_1234, 32'h0000_0100, 0, 0, -1, 0, 1'b0, -1);
    check("t1_trace_len", 64'(t_len), 64'd3);
    check("t1_done_cycle", 64'(t_dv[2]), 64'd1);

    // STOP, controller reaches CPU_CMD after 5 issue cycles
    run_txn(REQ_KIND_STOP, 32'hCAFE_0002, 32'h0000_0200, 4, 0, -1, 0, 1'b0, -1);
    check("t2_trace_len", 64'(t_len), 64'd7);
    check("t2_stop_done", 64'(t_msg[6]), 64'(CPU_R_STOP_DONE));

    // two refusals (codes 0 and 2), then accepted
    run_txn(REQ_KIND_RUN, 32'h0000_0003, 32'h0000_0300, 0, 2, -1, 0, 1'b0, -1);
    check("t3_trace_len", 64'(t_len), 64'd13);
    check("t3_third_window", 64'(t_cmd[10]), 64'(THREAD_CMD_RUN));

    // always refused: four attempts, done_ok=0, no message
    run_txn(REQ_KIND_RUN, 32'h0000_0004, 32'h0000_0400, 0, 4, -1, 0, 1'b0, -1);
    check("t4_trace_len", 64'(t_len), 64'd18);
    check("t4_done_ok", 64'(t_ok[17]), 64'd0);

    // clock enable low for 2 cycles mid-issue, extra request held while busy
    run_txn(REQ_KIND_RUN, 32'h0000_0005, 32'h0000_0500, 2, 0, 1, 2, 1'b1, -1);
    check("t5_trace_len", 64'(t_len), 64'd5);

    // reset during back-off abandons the request
    run_txn(REQ_KIND_STOP, 32'h0000_0006, 32'h0000_0600, 0, 4, -1, 0, 1'b0, 3);

    // the issuer is usable again after the abandoned request
    run_txn(REQ_KIND_STOP, 32'h0000_0007, 32'h0000_0700, 1, 1, -1, 0, 1'b0, -1);
    check("t7_trace_len", 64'(t_len), 64'd10);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
